fv_sb_wolper_mc: RTL
====================

FV_SB_WOLPER_MC -- requirements
Module: fv_sb_wolper_mc

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: push/pop payload width.
REQ-002 SHALL have parameter NUM_CH, default 4: channel count; CHW = max(1, clog2(NUM_CH)).
REQ-003 SHALL have parameter MAX_LAT, default 16: push-to-pop latency bound in cycles; LW = clog2(MAX_LAT+1).
REQ-004 SHALL have parameter ORDERED, default 1: 1 = per-channel in-order delivery is checked; 0 = out-of-order delivery is allowed.
REQ-005 SHALL have parameter BYPASS, default 0: 1 = a symbol's pop in the same cycle as its push is legal.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rstn  input  1  asynchronous, active-low reset.
REQ-008 push_valid / push_ch / push_data  input  1 / CHW / DWIDTH  ingress beat.
REQ-009 pop_valid / pop_ch / pop_data  input  1 / CHW / DWIDTH  egress beat.
REQ-010 special_a, special_b  input  DWIDTH each  watched symbols A and B (free variables in formal).
REQ-011 a_state, b_state  output  2 each  symbol FSM state: 0 IDLE, 1 INFLT, 2 DONE.
REQ-012 a_lat, b_lat  output  LW each  in-flight latency counters.
REQ-013 err_causality, err_dup, err_chan, err_order, err_timeout  output  1 each  sticky error flags.
REQ-014 err_any  output  1  OR of the five error flags.

Function
REQ-015 SHALL assume special_a and special_b are stable from the first cycle after reset and special_a != special_b.
REQ-016 SHALL assume each symbol is pushed at most once after reset (a push_valid carrying a symbol whose FSM is not IDLE is excluded).
REQ-017 Per-symbol FSM transitions SHALL be: IDLE->INFLT on a push of that symbol; INFLT->DONE on a pop of that symbol; DONE is terminal until reset.
REQ-018 On the push, the FSM SHALL record push_ch; on the matching pop, err_chan SHALL be set if pop_ch differs from the recorded channel.
REQ-019 err_causality SHALL be set on a pop of a symbol whose FSM is IDLE, except when BYPASS=1 and a push of that symbol occurs in the same cycle; that case goes IDLE->DONE directly.
REQ-020 err_dup SHALL be set on a pop of a symbol whose FSM is DONE.
REQ-021 The latency counter SHALL clear on push, increment by one each cycle in INFLT, and saturate at MAX_LAT.
REQ-022 err_timeout SHALL be set when a symbol is in INFLT with its counter equal to MAX_LAT and no pop of that symbol occurs in that cycle.
REQ-023 SHALL register a_first = 1 when A is pushed while B is IDLE, on the same channel as B's later push; pushes in the same cycle do not set it.
REQ-024 With ORDERED=1, err_order SHALL be set when B is popped while A is INFLT and a_first=1; the symmetric check applies with b_first. With ORDERED=0, err_order SHALL stay 0.
REQ-025 A simultaneous pop of A and B SHALL be checked independently per symbol; the order check SHALL treat it as a violation only when both symbols share a channel.
REQ-026 Error flags SHALL be registered: each asserts the cycle after the offending beat and stays high until reset.
REQ-027 Each flag SHALL have a matching concurrent assertion that its value is never 1, disabled while rstn is low.
REQ-028 Beats with push_valid or pop_valid low SHALL be ignored regardless of data or channel.

Reset
REQ-029 While rstn is low, both FSMs SHALL be IDLE, counters 0, a_first/b_first 0, and all err_* 0.
REQ-030 A reset in the middle of a transaction SHALL discard all tracking; an orphan pop after reset SHALL be judged against IDLE state.

Configuration
REQ-031 With macro FV_SB_WOLPER_MC_LIVENESS_EN defined, SHALL add an s_eventually assertion per symbol: INFLT |-> s_eventually DONE.
REQ-032 Without FV_SB_WOLPER_MC_LIVENESS_EN, SHALL provide only the bounded err_timeout check; all ports are unchanged.

Verification
REQ-033 A=8'h5A pushed ch1 at cycle 2, popped ch1 at cycle 6 -> a_state goes 1 then 2, a_lat=4 at the pop, err_any stays 0.
REQ-034 Pop of 8'h5A at cycle 3 with no prior push -> err_causality=1 at cycle 4; repeating with BYPASS=1 and a same-cycle push -> no error.
REQ-035 A pushed ch0 at cycle 1, B pushed ch0 at cycle 2, B popped at cycle 5 and A at cycle 6 with ORDERED=1 -> err_order=1 at cycle 6; the same stimulus with ORDERED=0 -> no error.
REQ-036 A pushed ch2, popped ch3 -> err_chan=1; a second pop of A -> err_dup=1.
REQ-037 MAX_LAT=4, A pushed at cycle 0 and never popped -> a_lat saturates at 4 and err_timeout=1 at cycle 5; rstn pulsed low at cycle 7 -> all outputs 0.

Source files
------------

// File: rtl/fv_sb_wolper_mc.sv
// ---------------------------------------------------------------------------
// fv_sb_wolper_mc -- Wolper-style two-symbol scoreboard checker.
//
// Two watched symbols, A (special_a) and B (special_b), are followed through
// a multi-channel push/pop path. Each symbol has its own small tracker:
//   IDLE -> INFLT on push, INFLT -> DONE on pop, DONE is terminal.
// The push channel and the cycles spent in flight are recorded. Protocol
// violations raise sticky error flags one cycle after the offending beat:
// causality, duplicate, channel, per-channel order, and latency timeout.
//
// Parameters
//   DWIDTH   payload width
//   NUM_CH   channel count (CHW = max(1, clog2(NUM_CH)))
//   MAX_LAT  push-to-pop latency bound (LW = clog2(MAX_LAT+1)), must be >= 1
//   ORDERED  1: per-channel in-order delivery is checked
//   BYPASS   1: a pop in the same cycle as the push is legal
//
// Ports
//   clk, rstn                        clock, async active-low reset
//   push_valid/push_ch/push_data     ingress beat
//   pop_valid/pop_ch/pop_data        egress beat
//   special_a, special_b             watched symbols
//   a_state, b_state                 0 IDLE, 1 INFLT, 2 DONE
//   a_lat, b_lat                     cycles elapsed since the push
//   err_causality/dup/chan/order/timeout, err_any   sticky error flags
//
// Build options
//   FV_SB_WOLPER_MC_LIVENESS_EN  adds an unbounded liveness property per
//                                symbol (INFLT |-> s_eventually DONE).
//   FORMAL                       enables the environment assumptions and the
//                                never-error assertions for a formal run.
// ---------------------------------------------------------------------------

package fv_sb_wolper_mc_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INFLT = 2'd1,
    ST_DONE  = 2'd2
  } sym_state_e;
endpackage

// ---------------------------------------------------------------------------
// fv_sb_wolper_sym -- tracker for one watched symbol.
//   push_hit/pop_hit are the decoded "this beat carries my symbol" strobes.
//   ev_* are single-cycle violation events, registered by the parent.
// ---------------------------------------------------------------------------
module fv_sb_wolper_sym
  import fv_sb_wolper_mc_pkg::*;
#(
  parameter int CHW     = 2,
  parameter int LW      = 5,
  parameter int MAX_LAT = 16,
  parameter int BYPASS  = 0
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           push_hit,
  input  logic [CHW-1:0] push_ch,
  input  logic           pop_hit,
  input  logic [CHW-1:0] pop_ch,
  output sym_state_e     state,
  output logic [LW-1:0]  lat,
  output logic [CHW-1:0] ch,
  output logic           ev_causality,
  output logic           ev_dup,
  output logic           ev_chan,
  output logic           ev_timeout
);

  localparam logic [LW-1:0] LAT_MAX = LW'(MAX_LAT);

  // Push and pop of the symbol in the same cycle, legal only with BYPASS.
  logic bypass_hit;
  assign bypass_hit = (BYPASS != 0) && push_hit && pop_hit;

  always_comb begin
    ev_causality = 1'b0;
    ev_dup       = 1'b0;
    ev_chan      = 1'b0;
    ev_timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        ev_causality = pop_hit && !bypass_hit;
        // A bypassed pop still has to leave on the channel it came in on.
        ev_chan      = bypass_hit && (pop_ch != push_ch);
      end
      ST_INFLT: begin
        ev_chan    = pop_hit && (pop_ch != ch);
        ev_timeout = !pop_hit && (lat == LAT_MAX);
      end
      ST_DONE: ev_dup = pop_hit;
      default: ;
    endcase
  end

  // lat reads as the number of cycles since the push: it loads 1 on the
  // push edge, counts while in flight, saturates at MAX_LAT and freezes on
  // the pop so it keeps the observed latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      lat   <= '0;
      ch    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (push_hit) begin
            ch <= push_ch;
            if (bypass_hit) begin
              state <= ST_DONE;
              lat   <= '0;
            end else begin
              state <= ST_INFLT;
              lat   <= LW'(1);
            end
          end
        end
        ST_INFLT: begin
          if (pop_hit)              state <= ST_DONE;
          else if (lat != LAT_MAX)  lat   <= lat + LW'(1);
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// ---------------------------------------------------------------------------
// fv_sb_wolper_mc -- top: symbol decode, two trackers, order check, flags.
// ---------------------------------------------------------------------------
module fv_sb_wolper_mc
  import fv_sb_wolper_mc_pkg::*;
#(
  parameter  int DWIDTH  = 8,
  parameter  int NUM_CH  = 4,
  parameter  int MAX_LAT = 16,
  parameter  int ORDERED = 1,
  parameter  int BYPASS  = 0,
  localparam int CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LW      = $clog2(MAX_LAT + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push_valid,
  input  logic [CHW-1:0]    push_ch,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop_valid,
  input  logic [CHW-1:0]    pop_ch,
  input  logic [DWIDTH-1:0] pop_data,
  input  logic [DWIDTH-1:0] special_a,
  input  logic [DWIDTH-1:0] special_b,
  output logic [1:0]        a_state,
  output logic [1:0]        b_state,
  output logic [LW-1:0]     a_lat,
  output logic [LW-1:0]     b_lat,
  output logic              err_causality,
  output logic              err_dup,
  output logic              err_chan,
  output logic              err_order,
  output logic              err_timeout,
  output logic              err_any
);

  // Index 0 is symbol A, index 1 is symbol B.
  logic [1:0][DWIDTH-1:0] special;
  logic [1:0]             push_hit, pop_hit;
  sym_state_e             st [2];
  logic [1:0][LW-1:0]     lat;
  logic [1:0][CHW-1:0]    ch;
  logic [1:0]             ev_caus, ev_dup, ev_chan, ev_tmo;
  logic [1:0]             first;   // first[s]: s was pushed ahead of the other on a shared channel
  logic                   ev_order;

  assign special = {special_b, special_a};

  for (genvar s = 0; s < 2; s++) begin : g_sym
    assign push_hit[s] = push_valid && (push_data == special[s]);
    assign pop_hit[s]  = pop_valid  && (pop_data  == special[s]);

    fv_sb_wolper_sym #(
      .CHW     (CHW),
      .LW      (LW),
      .MAX_LAT (MAX_LAT),
      .BYPASS  (BYPASS)
    ) u_sym (
      .clk          (clk),
      .rstn         (rstn),
      .push_hit     (push_hit[s]),
      .push_ch      (push_ch),
      .pop_hit      (pop_hit[s]),
      .pop_ch       (pop_ch),
      .state        (st[s]),
      .lat          (lat[s]),
      .ch           (ch[s]),
      .ev_causality (ev_caus[s]),
      .ev_dup       (ev_dup[s]),
      .ev_chan      (ev_chan[s]),
      .ev_timeout   (ev_tmo[s])
    );
  end

  // Popping the later symbol while the earlier one (same channel) is still
  // in flight breaks per-channel FIFO order. There is a single pop beat per
  // cycle and the symbols differ, so A and B can never pop together; each
  // pop is judged on its own.
  assign ev_order = (ORDERED != 0) &&
                    ((pop_hit[1] && (st[0] == ST_INFLT) && first[0]) ||
                     (pop_hit[0] && (st[1] == ST_INFLT) && first[1]));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      first         <= '0;
      err_causality <= 1'b0;
      err_dup       <= 1'b0;
      err_chan      <= 1'b0;
      err_order     <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      // Ordering is latched when the second symbol arrives on the channel
      // the first one already holds; only one push per cycle is possible.
      if (push_hit[1] && (st[1] == ST_IDLE) && (st[0] != ST_IDLE) && (ch[0] == push_ch))
        first[0] <= 1'b1;
      if (push_hit[0] && (st[0] == ST_IDLE) && (st[1] != ST_IDLE) && (ch[1] == push_ch))
        first[1] <= 1'b1;
      if (|ev_caus) err_causality <= 1'b1;
      if (|ev_dup)  err_dup       <= 1'b1;
      if (|ev_chan) err_chan      <= 1'b1;
      if (ev_order) err_order     <= 1'b1;
      if (|ev_tmo)  err_timeout   <= 1'b1;
    end
  end

  assign a_state = st[0];
  assign b_state = st[1];
  assign a_lat   = lat[0];
  assign b_lat   = lat[1];
  assign err_any = err_causality | err_dup | err_chan | err_order | err_timeout;

`ifdef FORMAL
  // Environment: symbols are stable and distinct, each pushed at most once.
  asm_stable_a: assume property (@(posedge clk) disable iff (!rstn) $stable(special_a));
  asm_stable_b: assume property (@(posedge clk) disable iff (!rstn) $stable(special_b));
  asm_distinct: assume property (@(posedge clk) disable iff (!rstn) special_a != special_b);
  asm_once_a:   assume property (@(posedge clk) disable iff (!rstn) push_hit[0] |-> st[0] == ST_IDLE);
  asm_once_b:   assume property (@(posedge clk) disable iff (!rstn) push_hit[1] |-> st[1] == ST_IDLE);

  ast_no_causality: assert property (@(posedge clk) disable iff (!rstn) !err_causality);
  ast_no_dup:       assert property (@(posedge clk) disable iff (!rstn) !err_dup);
  ast_no_chan:      assert property (@(posedge clk) disable iff (!rstn) !err_chan);
  ast_no_order:     assert property (@(posedge clk) disable iff (!rstn) !err_order);
  ast_no_timeout:   assert property (@(posedge clk) disable iff (!rstn) !err_timeout);
`endif

`ifdef FV_SB_WOLPER_MC_LIVENESS_EN
  ast_live_a: assert property (@(posedge clk) disable iff (!rstn)
                               (st[0] == ST_INFLT) |-> s_eventually (st[0] == ST_DONE));
  ast_live_b: assert property (@(posedge clk) disable iff (!rstn)
                               (st[1] == ST_INFLT) |-> s_eventually (st[1] == ST_DONE));
`else
  // Only the bounded latency check (err_timeout) guards progress.
`endif

endmodule
